// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel and
// the valid/ready channel towards decode. master = fetch unit side.
interface fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_resp_valid;
  logic [INST_W-1:0] imem_resp_data;
  logic              dec_valid;
  logic [INST_W-1:0] dec_inst;
  logic [ADDR_W-1:0] dec_pc;
  logic              dec_ready;

  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_inst, dec_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_inst, dec_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, dec_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order imem requests at the current PC,
// tags them with their PC, buffers returned words in a DEPTH-entry queue for
// decode, and handles execute-stage redirects by draining stale responses.
module fetch_unit #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic [1:0]        pc_cmd,
  output logic [ADDR_W-1:0] pc_load_addr,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_target,
  fetch_unit_if.master      bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {RUN, DRAIN} state_e;
  typedef enum logic [1:0] {
    PC_HOLD = 2'd0, PC_INC = 2'd1, PC_INC_OFFSET = 2'd2, PC_LOAD = 2'd3
  } pc_cmd_e;

  state_e            state, state_nx;
  logic [CW-1:0]     q_count, outstanding, discard, discard_nx;
  logic [PW-1:0]     q_head, q_tail, t_head, t_tail;
  logic [INST_W-1:0] q_inst [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [ADDR_W-1:0] tag_mem[DEPTH];
  logic [CW:0]       occupancy;
  logic              resp, issue, accept, push, pop, redirect;
  pc_cmd_e           cmd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake terms; reset gating keeps the request and redirect outputs quiet while rst is low
  assign redirect  = rst && flush;
  assign resp      = bus.imem_resp_valid && (outstanding != '0);
  assign occupancy = {1'b0, q_count} + {1'b0, outstanding};
  assign issue     = rst && (state == RUN) && !flush && (occupancy < (CW + 1)'(DEPTH));
  assign accept    = issue && bus.imem_req_ready;
  assign push      = resp && (state == RUN) && !flush;
  assign pop       = bus.dec_valid && bus.dec_ready && !flush;

  assign bus.imem_req_valid = issue;
  assign bus.imem_req_addr  = pc;
  assign bus.dec_valid      = (q_count != '0);
  assign bus.dec_inst       = q_inst[q_head];
  assign bus.dec_pc         = q_pc[q_head];
  assign pc_cmd             = cmd;
  assign pc_load_addr       = redirect ? flush_target : '0;

  // PC command: redirect beats an accepted request, otherwise hold
  always_comb begin
    cmd = PC_HOLD;
    if (redirect)    cmd = PC_LOAD;
    else if (accept) cmd = PC_INC;
  end

  // Next state and discard count; a response in the flush cycle is already consumed
  always_comb begin
    state_nx   = state;
    discard_nx = discard;
    if (flush) begin
      discard_nx = outstanding - CW'(resp);
      state_nx   = (discard_nx != '0) ? DRAIN : RUN;
    end else if (state == DRAIN && resp) begin
      discard_nx = discard - CW'(1);
      if (discard_nx == '0) state_nx = RUN;
    end
  end

  // State and discard registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      discard <= '0;
    end else begin
      state   <= state_nx;
      discard <= discard_nx;
    end
  end

  // Outstanding request count; no request is accepted in a flush cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) outstanding <= '0;
    else      outstanding <= outstanding + CW'(accept) - CW'(resp);
  end

  // Tag FIFO pointers; in DRAIN the FIFO is empty so responses leave it untouched
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_head <= '0;
      t_tail <= '0;
    end else if (flush) begin
      t_head <= '0;
      t_tail <= '0;
    end else begin
      if (accept) t_tail <= ptr_inc(t_tail);
      if (push)   t_head <= ptr_inc(t_head);
    end
  end

  // Tag FIFO storage
  always_ff @(posedge clk) begin
    if (accept) tag_mem[t_tail] <= pc;
  end

  // Decode queue pointers and count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_head  <= '0;
      q_tail  <= '0;
      q_count <= '0;
    end else if (flush) begin
      q_head  <= '0;
      q_tail  <= '0;
      q_count <= '0;
    end else begin
      if (push) q_tail <= ptr_inc(q_tail);
      if (pop)  q_head <= ptr_inc(q_head);
      q_count <= q_count + CW'(push) - CW'(pop);
    end
  end

  // Decode queue storage: word plus the PC it was fetched from
  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[q_tail] <= bus.imem_resp_data;
      q_pc[q_tail]   <= tag_mem[t_head];
    end
  end

  // A response with nothing in flight is a memory protocol error
  resp_without_request: assert property (
    @(posedge clk) disable iff (!rst) bus.imem_resp_valid |-> (outstanding != '0)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC register and instruction memory environment,
// a directed cycle table, hand sequences for reset, and a randomized run
// checked against a generation-based stream model.
module tb_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [1:0] C_HOLD = 2'd0, C_INC = 2'd1, C_LOAD = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc;
  logic [1:0]  pc_cmd;
  logic [31:0] pc_load_addr;
  logic        flush = 1'b0;
  logic [31:0] flush_target = '0;

  fetch_unit_if #(.ADDR_W(32), .INST_W(32)) bus ();

  fetch_unit #(.DEPTH(DEPTH), .ADDR_W(32), .INST_W(32)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_cmd(pc_cmd), .pc_load_addr(pc_load_addr),
    .flush(flush), .flush_target(flush_target), .bus(bus)
  );

  always #5 clk = ~clk;

  // PC register driven by the fetch unit's command
  always @(posedge clk or negedge rst) begin
    if (!rst) pc <= 32'h0;
    else case (pc_cmd)
      C_INC:   pc <= pc + 32'd4;
      C_LOAD:  pc <= pc_load_addr;
      default: ;
    endcase
  end

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  typedef struct { logic [31:0] addr; int gen; int cyc; } req_t;
  typedef struct {
    bit rr, rv, dr, fl;
    bit rqv; logic [31:0] addr; logic [1:0] cmd; bit dv; logic [31:0] dpc;
  } vec_t;

  req_t        env_q[$];
  vec_t        tbl[$];
  int          vectors = 0, miscompares = 0;
  int          gen = 0, accepted = 0, got = 0, popped = 0, cyc = 0, pops_total = 0;
  logic [31:0] exp_pc = 32'h0;

  function automatic vec_t mk(input bit rr, rv, dr, fl, rqv, input logic [31:0] addr,
                              input logic [1:0] cmd, input bit dv, input logic [31:0] dpc);
    vec_t v;
    v.rr = rr; v.rv = rv; v.dr = dr; v.fl = fl;
    v.rqv = rqv; v.addr = addr; v.cmd = cmd; v.dv = dv; v.dpc = dpc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    env_q.delete();
    gen = 0; accepted = 0; got = 0; popped = 0; exp_pc = 32'h0;
  endtask

  // Drive one cycle's inputs at the falling edge, outputs settle 1 time unit later
  task automatic drive(input bit rr, rv, dr, fl, input logic [31:0] tgt);
    @(negedge clk);
    bus.imem_req_ready  = rr;
    bus.imem_resp_valid = rv && (env_q.size() > 0);
    bus.imem_resp_data  = (rv && env_q.size() > 0) ? mem(env_q[0].addr) : $urandom;
    bus.dec_ready       = dr;
    flush               = fl;
    flush_target        = tgt;
    #1;
  endtask

  // Cross the rising edge and update the memory environment and stream model
  task automatic advance();
    bit acc, rvs, fl, dr, edv;
    logic [31:0] tgt, pcs;
    acc = bus.imem_req_valid && bus.imem_req_ready;
    rvs = bus.imem_resp_valid;
    fl  = flush;
    dr  = bus.dec_ready;
    tgt = flush_target;
    pcs = pc;
    edv = (got > popped);
    @(posedge clk);
    if (rvs && env_q.size() > 0) begin
      if (!fl && env_q[0].gen == gen) got++;
      void'(env_q.pop_front());
    end
    if (acc) env_q.push_back('{addr: pcs, gen: gen, cyc: cyc});
    if (fl) begin
      gen++; accepted = 0; got = 0; popped = 0; exp_pc = tgt;
    end else begin
      if (acc) accepted++;
      if (edv && dr) begin popped++; pops_total++; exp_pc = exp_pc + 32'd4; end
    end
    cyc++;
  endtask

  initial begin
    bit rr, rv, dr, fl, exp_rqv, exp_dv;
    logic [31:0] tgt;
    logic [1:0]  exp_cmd;
    int stale;

    bus.imem_req_ready = 0; bus.imem_resp_valid = 0; bus.imem_resp_data = '0; bus.dec_ready = 0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_dec_valid", bus.dec_valid, 0);
    check("rst_req_valid", bus.imem_req_valid, 0);
    check("rst_pc_cmd", pc_cmd, C_HOLD);
    check("rst_load_addr", pc_load_addr, 0);
    model_reset();
    rst = 1'b1;

    // Two accepted requests, then reset asserted mid-cycle
    drive(1, 0, 0, 0, 0);
    check("t1_rqv0", bus.imem_req_valid, 1); check("t1_addr0", bus.imem_req_addr, 32'h0);
    check("t1_cmd0", pc_cmd, C_INC);
    advance();
    drive(1, 0, 0, 0, 0);
    check("t1_addr1", bus.imem_req_addr, 32'h4); check("t1_cmd1", pc_cmd, C_INC);
    advance();
    #2 rst = 1'b0;
    #1;
    check("t1_async_dv", bus.dec_valid, 0);
    check("t1_async_rqv", bus.imem_req_valid, 0);
    check("t1_async_cmd", pc_cmd, C_HOLD);
    bus.imem_req_ready = 0; bus.dec_ready = 0;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b1;
    #1;
    check("t1_post_rqv", bus.imem_req_valid, 1);
    check("t1_post_addr", bus.imem_req_addr, 32'h0);

    // Directed cycle table: stall, backpressure, drain flush, flush with response and pop
    tbl.push_back(mk(0,0,0,0, 1,32'h000,C_HOLD,0,32'h0));
    tbl.push_back(mk(0,0,0,0, 1,32'h000,C_HOLD,0,32'h0));
    tbl.push_back(mk(0,0,0,0, 1,32'h000,C_HOLD,0,32'h0));
    tbl.push_back(mk(1,0,0,0, 1,32'h000,C_INC ,0,32'h0));
    tbl.push_back(mk(1,0,0,0, 1,32'h004,C_INC ,0,32'h0));
    tbl.push_back(mk(1,1,0,0, 0,32'h008,C_HOLD,0,32'h0));
    tbl.push_back(mk(1,1,0,0, 0,32'h008,C_HOLD,1,32'h0));
    tbl.push_back(mk(1,0,0,0, 0,32'h008,C_HOLD,1,32'h0));
    tbl.push_back(mk(1,0,1,0, 0,32'h008,C_HOLD,1,32'h0));
    tbl.push_back(mk(1,0,1,0, 1,32'h008,C_INC ,1,32'h4));
    tbl.push_back(mk(1,1,1,0, 1,32'h00c,C_INC ,0,32'h0));
    tbl.push_back(mk(1,1,1,0, 0,32'h010,C_HOLD,1,32'h8));
    tbl.push_back(mk(1,0,1,0, 1,32'h010,C_INC ,1,32'hc));
    tbl.push_back(mk(1,0,0,0, 1,32'h014,C_INC ,0,32'h0));
    tbl.push_back(mk(0,0,0,1, 0,32'h018,C_LOAD,0,32'h0));
    tbl.push_back(mk(1,1,0,0, 0,32'h100,C_HOLD,0,32'h0));
    tbl.push_back(mk(1,1,0,0, 0,32'h100,C_HOLD,0,32'h0));
    tbl.push_back(mk(1,0,1,0, 1,32'h100,C_INC ,0,32'h0));
    tbl.push_back(mk(0,1,0,0, 1,32'h104,C_HOLD,0,32'h0));
    tbl.push_back(mk(0,0,0,0, 1,32'h104,C_HOLD,1,32'h100));
    tbl.push_back(mk(1,0,0,0, 1,32'h104,C_INC ,1,32'h100));
    tbl.push_back(mk(0,1,1,1, 0,32'h108,C_LOAD,1,32'h100));
    tbl.push_back(mk(0,0,1,0, 1,32'h100,C_HOLD,0,32'h0));
    tbl.push_back(mk(1,0,0,0, 1,32'h100,C_INC ,0,32'h0));
    tbl.push_back(mk(0,1,0,0, 1,32'h104,C_HOLD,0,32'h0));
    tbl.push_back(mk(0,0,0,0, 1,32'h104,C_HOLD,1,32'h100));
    foreach (tbl[i]) begin
      drive(tbl[i].rr, tbl[i].rv, tbl[i].dr, tbl[i].fl, 32'h100);
      check($sformatf("tbl%0d_rqv", i), bus.imem_req_valid, tbl[i].rqv);
      check($sformatf("tbl%0d_addr", i), bus.imem_req_addr, tbl[i].addr);
      check($sformatf("tbl%0d_cmd", i), pc_cmd, tbl[i].cmd);
      check($sformatf("tbl%0d_load", i), pc_load_addr, tbl[i].fl ? 32'h100 : 32'h0);
      check($sformatf("tbl%0d_dv", i), bus.dec_valid, tbl[i].dv);
      if (tbl[i].dv) begin
        check($sformatf("tbl%0d_dpc", i), bus.dec_pc, tbl[i].dpc);
        check($sformatf("tbl%0d_dinst", i), bus.dec_inst, mem(tbl[i].dpc));
      end
      advance();
    end

    // Fresh start for the randomized run
    @(negedge clk);
    bus.imem_req_ready = 0; bus.imem_resp_valid = 0; bus.dec_ready = 0; flush = 0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      rr  = ($urandom_range(0, 3) != 0);
      rv  = (env_q.size() > 0) && (env_q[0].cyc < cyc) && ($urandom_range(0, 2) != 0);
      dr  = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 39) == 0);
      tgt = $urandom & 32'h0000_FFFC;
      drive(rr, rv, dr, fl, tgt);
      stale = 0;
      foreach (env_q[k]) if (env_q[k].gen != gen) stale++;
      exp_rqv = !fl && (stale == 0) && ((accepted - popped) < DEPTH);
      exp_dv  = (got > popped);
      exp_cmd = fl ? C_LOAD : ((exp_rqv && rr) ? C_INC : C_HOLD);
      check("rnd_rqv", bus.imem_req_valid, exp_rqv);
      check("rnd_addr", bus.imem_req_addr, pc);
      check("rnd_cmd", pc_cmd, exp_cmd);
      check("rnd_load", pc_load_addr, fl ? tgt : 32'h0);
      check("rnd_dv", bus.dec_valid, exp_dv);
      if (exp_dv && dr && !fl) begin
        check("rnd_dpc", bus.dec_pc, exp_pc);
        check("rnd_dinst", bus.dec_inst, mem(exp_pc));
      end
      advance();
    end
    check("rnd_progress", (pops_total >= 100) ? 1 : 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
